// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle MIPS control FSM with handshaked memory; define MIPS_MC_ADDI_EN to add addi support.
module mips_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       retire,
  output logic       illegal_op
);
`ifdef MIPS_MC_ADDI_EN
  typedef enum logic [3:0] {FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB} state_t;
`else
  typedef enum logic [3:0] {FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP} state_t;
`endif
  state_t state_q, state_d;
  logic req, mw, irw, pcw, br, rw, ret, ill;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= FETCH;
    else state_q <= state_d;
  always_comb begin
    state_d = FETCH;
    {req, mw, irw, pcw, br, rw, ret, ill} = '0;
    {iord, alusrca, regdst, memtoreg} = '0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    alucontrol = 3'b010;
    case (state_q)
      FETCH: begin
        req = 1'b1;
        alusrcb = 2'b01;
        irw = mem_ready;
        pcw = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000000: state_d = EXEC;
          6'b000100: state_d = BRANCH;
          6'b000010: state_d = JUMP;
`ifdef MIPS_MC_ADDI_EN
          6'b001000: state_d = ADDIEX;
`endif
          default: ill = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = op == 6'b100011 ? MEMRD : MEMWR;
      end
      MEMRD: begin
        req = 1'b1;
        iord = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: {memtoreg, rw, ret} = 3'b111;
      MEMWR: begin
        {req, iord, mw} = 3'b111;
        ret = mem_ready;
        state_d = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        alusrca = 1'b1;
        state_d = ALUWB;
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default: begin
            ill = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      ALUWB: {regdst, rw, ret} = 3'b111;
      BRANCH: begin
        alusrca = 1'b1;
        alucontrol = 3'b110;
        pcsrc = 2'b01;
        {br, ret} = 2'b11;
      end
      JUMP: begin
        pcsrc = 2'b10;
        {pcw, ret} = 2'b11;
      end
`ifdef MIPS_MC_ADDI_EN
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: {rw, ret} = 2'b11;
`endif
      default: state_d = FETCH;
    endcase
  end
  // Strobes are forced low by reset itself so they drop without waiting for a clock
  assign mem_req    = reset & req;
  assign memwrite   = reset & mw;
  assign irwrite    = reset & irw;
  assign pcen       = reset & (pcw | (br & zero));
  assign regwrite   = reset & rw;
  assign retire     = reset & ret;
  assign illegal_op = reset & ill;
endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller: per-cycle vector table for the multicycle controller plus an async-reset sequence.
module tb_mips_mc_controller;
  logic clk = 1'b0, reset = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] op = 6'b0, funct = 6'b0;
  logic mem_req, memwrite, irwrite, pcen, regwrite, iord, alusrca, regdst, memtoreg, retire, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  int tests = 0, failed = 0;
  always #5 clk = ~clk;
  mips_mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen), .regwrite(regwrite),
    .iord(iord), .alusrca(alusrca), .regdst(regdst), .memtoreg(memtoreg), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .retire(retire), .illegal_op(illegal_op)
  );
  // {mem_req,memwrite,irwrite,pcen,regwrite}_{iord,alusrca,regdst,memtoreg}_alusrcb_pcsrc_alucontrol_{retire,illegal_op}
  localparam logic [17:0] E_RST  = 18'b00000_0000_01_00_010_00;
  localparam logic [17:0] E_F1   = 18'b10110_0000_01_00_010_00;
  localparam logic [17:0] E_F0   = 18'b10000_0000_01_00_010_00;
  localparam logic [17:0] E_DEC  = 18'b00000_0000_11_00_010_00;
  localparam logic [17:0] E_DECI = 18'b00000_0000_11_00_010_01;
  localparam logic [17:0] E_MADR = 18'b00000_0100_10_00_010_00;
  localparam logic [17:0] E_MRD  = 18'b10000_1000_00_00_010_00;
  localparam logic [17:0] E_MWB  = 18'b00001_0001_00_00_010_10;
  localparam logic [17:0] E_MWR0 = 18'b11000_1000_00_00_010_00;
  localparam logic [17:0] E_MWR1 = 18'b11000_1000_00_00_010_10;
  localparam logic [17:0] E_XADD = 18'b00000_0100_00_00_010_00;
  localparam logic [17:0] E_XSUB = 18'b00000_0100_00_00_110_00;
  localparam logic [17:0] E_XSLT = 18'b00000_0100_00_00_111_00;
  localparam logic [17:0] E_XILL = 18'b00000_0100_00_00_010_01;
  localparam logic [17:0] E_AWB  = 18'b00001_0010_00_00_010_10;
  localparam logic [17:0] E_BRT  = 18'b00010_0100_00_01_110_10;
  localparam logic [17:0] E_BRF  = 18'b00000_0100_00_01_110_10;
  localparam logic [17:0] E_JMP  = 18'b00010_0000_00_10_010_10;
  localparam logic [17:0] E_AIWB = 18'b00001_0000_00_00_010_10;
  typedef struct {
    string      name;
    logic       rn;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mr;
    logic [17:0] exp;
  } vec_t;
  vec_t tbl[$];
  function automatic logic [17:0] outs();
    return {mem_req, memwrite, irwrite, pcen, regwrite, iord, alusrca, regdst, memtoreg,
            alusrcb, pcsrc, alucontrol, retire, illegal_op};
  endfunction
  task automatic add(input string n, input logic rn, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic mr, input logic [17:0] e);
    vec_t v;
    v.name = n; v.rn = rn; v.op = o; v.funct = f; v.zero = z; v.mr = mr; v.exp = e;
    tbl.push_back(v);
  endtask
  task automatic chk(input string n, input logic [17:0] e);
    logic [17:0] g;
    g = outs();
    tests++;
    if (g !== e) begin
      failed++;
      $display("FAIL %s: got %b expected %b", n, g, e);
    end
  endtask
  initial begin
    add("rst0", 0, 6'b100011, 0, 0, 1, E_RST);
    add("rst1", 0, 6'b100011, 0, 0, 1, E_RST);
    add("lw_fetch", 1, 6'b100011, 0, 0, 1, E_F1);
    add("lw_dec", 1, 6'b100011, 0, 0, 1, E_DEC);
    add("lw_madr", 1, 6'b100011, 0, 0, 1, E_MADR);
    add("lw_mrd", 1, 6'b100011, 0, 0, 1, E_MRD);
    add("lw_mwb", 1, 6'b100011, 0, 0, 1, E_MWB);
    add("sw_fetch", 1, 6'b101011, 0, 0, 1, E_F1);
    add("sw_dec", 1, 6'b101011, 0, 0, 1, E_DEC);
    add("sw_madr", 1, 6'b101011, 0, 0, 1, E_MADR);
    add("sw_mwr", 1, 6'b101011, 0, 0, 1, E_MWR1);
    add("fwait1", 1, 6'b000000, 6'b101010, 0, 0, E_F0);
    add("fwait2", 1, 6'b000000, 6'b101010, 0, 0, E_F0);
    add("fwait3", 1, 6'b000000, 6'b101010, 0, 0, E_F0);
    add("fwait4", 1, 6'b000000, 6'b101010, 0, 1, E_F1);
    add("slt_dec", 1, 6'b000000, 6'b101010, 0, 1, E_DEC);
    add("slt_exec", 1, 6'b000000, 6'b101010, 0, 1, E_XSLT);
    add("slt_awb", 1, 6'b000000, 6'b101010, 0, 1, E_AWB);
    add("sub_fetch", 1, 6'b000000, 6'b100010, 0, 1, E_F1);
    add("sub_dec", 1, 6'b000000, 6'b100010, 0, 0, E_DEC);
    add("sub_exec", 1, 6'b000000, 6'b100010, 0, 0, E_XSUB);
    add("sub_awb", 1, 6'b000000, 6'b100010, 0, 0, E_AWB);
    add("rill_fetch", 1, 6'b000000, 6'b111111, 0, 1, E_F1);
    add("rill_dec", 1, 6'b000000, 6'b111111, 0, 1, E_DEC);
    add("rill_exec", 1, 6'b000000, 6'b111111, 0, 1, E_XILL);
    add("beqt_fetch", 1, 6'b000100, 0, 1, 1, E_F1);
    add("beqt_dec", 1, 6'b000100, 0, 1, 1, E_DEC);
    add("beqt_br", 1, 6'b000100, 0, 1, 1, E_BRT);
    add("beqf_fetch", 1, 6'b000100, 0, 0, 1, E_F1);
    add("beqf_dec", 1, 6'b000100, 0, 0, 1, E_DEC);
    add("beqf_br", 1, 6'b000100, 0, 0, 1, E_BRF);
    add("j_fetch", 1, 6'b000010, 0, 0, 1, E_F1);
    add("j_dec", 1, 6'b000010, 0, 0, 1, E_DEC);
    add("j_jump", 1, 6'b000010, 0, 0, 1, E_JMP);
    add("addi_fetch", 1, 6'b001000, 0, 0, 1, E_F1);
`ifdef MIPS_MC_ADDI_EN
    add("addi_dec", 1, 6'b001000, 0, 0, 1, E_DEC);
    add("addi_ex", 1, 6'b001000, 0, 0, 1, E_MADR);
    add("addi_wb", 1, 6'b001000, 0, 0, 1, E_AIWB);
`else
    add("addi_dec", 1, 6'b001000, 0, 0, 1, E_DECI);
`endif
    add("add_fetch", 1, 6'b000000, 6'b100000, 0, 1, E_F1);
    add("add_dec", 1, 6'b000000, 6'b100000, 0, 1, E_DEC);
    add("add_exec", 1, 6'b000000, 6'b100000, 0, 1, E_XADD);
    add("add_awb", 1, 6'b000000, 6'b100000, 0, 1, E_AWB);
    add("oill_fetch", 1, 6'b111111, 0, 0, 1, E_F1);
    add("oill_dec", 1, 6'b111111, 0, 0, 1, E_DECI);
    add("lww_fetch", 1, 6'b100011, 0, 0, 1, E_F1);
    add("lww_dec", 1, 6'b100011, 0, 0, 1, E_DEC);
    add("lww_madr", 1, 6'b100011, 0, 0, 1, E_MADR);
    add("lww_mrd0", 1, 6'b100011, 0, 0, 0, E_MRD);
    add("lww_mrd1", 1, 6'b100011, 0, 0, 0, E_MRD);
    add("lww_mrd2", 1, 6'b100011, 0, 0, 1, E_MRD);
    add("lww_mwb", 1, 6'b100011, 0, 0, 1, E_MWB);
    add("sww_fetch", 1, 6'b101011, 0, 0, 1, E_F1);
    add("sww_dec", 1, 6'b101011, 0, 0, 1, E_DEC);
    add("sww_madr", 1, 6'b101011, 0, 0, 1, E_MADR);
    add("sww_mwr0", 1, 6'b101011, 0, 0, 0, E_MWR0);
    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rn; op = tbl[i].op; funct = tbl[i].funct;
      zero = tbl[i].zero; mem_ready = tbl[i].mr;
      #1 chk(tbl[i].name, tbl[i].exp);
    end
    // still waiting in MEMWR; reset must cut memwrite without a clock edge
    @(negedge clk);
    #1 chk("mwr_wait", E_MWR0);
    reset = 1'b0;
    #1 chk("mwr_async_rst", E_RST);
    @(posedge clk);
    #1 chk("mwr_rst_held", E_RST);
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;
    #1 chk("post_rst_fetch", E_F0);
    @(negedge clk);
    mem_ready = 1'b1;
    #1 chk("post_rst_fetch_rdy", E_F1);
    @(negedge clk);
    #1 chk("post_rst_dec", E_DEC);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/mips_mc_controller.md
MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  async active-low reset; 0 = in reset.
REQ-004 op  in  6  instruction opcode, instr[31:26].
REQ-005 funct  in  6  R-type function field, instr[5:0].
REQ-006 zero  in  1  ALU zero flag from datapath.
REQ-007 mem_ready  in  1  memory completes current access this cycle.
REQ-008 mem_req  out  1  memory access request; held until mem_ready.
REQ-009 memwrite  out  1  memory write strobe.
REQ-010 irwrite  out  1  instruction register load enable.
REQ-011 pcen  out  1  PC load enable, = pcwrite | (branch & zero).
REQ-012 regwrite  out  1  register file write enable.
REQ-013 iord, alusrca, regdst, memtoreg  out  1 each  datapath mux selects.
REQ-014 alusrcb  out  2  00 rd2, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-015 pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-016 alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-017 retire  out  1  one-cycle pulse in final state of each instruction.
REQ-018 illegal_op  out  1  one-cycle pulse on unsupported op/funct.

Function
REQ-019 Moore FSM, states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP; unused encodings -> FETCH next cycle.
REQ-020 Unlisted outputs SHALL be 0 in each state; alucontrol default 010.
REQ-021 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01; irwrite and pcwrite=1 only when mem_ready=1; stay in FETCH while mem_ready=0, else DECODE.
REQ-022 DECODE: alusrca=0, alusrcb=11; next by op: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP, other -> FETCH with illegal_op=1.
REQ-023 MEMADR: alusrca=1, alusrcb=10; op 100011 -> MEMRD, else MEMWR.
REQ-024 MEMRD: mem_req=1, iord=1; wait for mem_ready, then MEMWB.
REQ-025 MEMWB: regdst=0, memtoreg=1, regwrite=1, retire=1 -> FETCH.
REQ-026 MEMWR: mem_req=1, iord=1, memwrite=1; wait for mem_ready; on mem_ready retire=1 -> FETCH.
REQ-027 EXEC: alusrca=1, alusrcb=00; funct 100000/100010/100100/100101/101010 -> 010/110/000/001/111; other funct -> 010, illegal_op=1, -> FETCH without ALUWB; legal -> ALUWB.
REQ-028 ALUWB: regdst=1, memtoreg=0, regwrite=1, retire=1 -> FETCH.
REQ-029 BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1, retire=1 -> FETCH.
REQ-030 ADDIEX: alusrca=1, alusrcb=10 -> ADDIWB; ADDIWB: regdst=0, memtoreg=0, regwrite=1, retire=1 -> FETCH.
REQ-031 JUMP: pcsrc=10, pcwrite=1, retire=1 -> FETCH.
REQ-032 Cycle counts with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-033 mem_ready outside a mem_req state SHALL be ignored.

Reset
REQ-034 reset=0 SHALL force state FETCH asynchronously and hold mem_req, memwrite, irwrite, pcen, regwrite, retire, illegal_op at 0 while asserted.
REQ-035 Reset mid-instruction (any state, incl. pending memory wait) SHALL abandon it; first edge after release begins FETCH with mem_req=1.

Configuration
REQ-036 Macro MIPS_MC_ADDI_EN defined: addi (op 001000) uses ADDIEX/ADDIWB.
REQ-037 Macro undefined: ADDIEX/ADDIWB absent; op 001000 in DECODE -> FETCH with illegal_op=1.

Verification
REQ-038 mem_ready=1 constant, lw (op 100011) -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1, memtoreg=1 in cycle 5; retire once.
REQ-039 FETCH with mem_ready=0 for 3 cycles then 1 -> mem_req=1 for 4 cycles, irwrite/pcen=1 only in 4th.
REQ-040 beq with zero=1 -> pcen=1, pcsrc=01 in BRANCH; zero=0 -> pcen=0; both 3 cycles.
REQ-041 R-type funct 101010 -> alucontrol=111 in EXEC, regdst=1 regwrite=1 in ALUWB; funct 111111 -> illegal_op pulse, no regwrite.
REQ-042 reset=0 asserted mid-MEMWR wait -> memwrite drops immediately; after release FETCH, mem_req=1.
REQ-043 op 001000: with MIPS_MC_ADDI_EN -> 4-cycle addi, regwrite in ADDIWB; without -> illegal_op in DECODE, back to FETCH.
